// File: rtl/cache_pkg.sv
// cache_pkg: default geometry and FSM state encoding shared by
// the cache miss handler and its victim pointer.
package cache_pkg;

   localparam int ADDR_W   = 16;
   localparam int DATA_W   = 32;
   localparam int NUM_WAYS = 256;
   localparam int TIMEOUT  = 255;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MEM_REQ,
      MEM_WAIT,
      FILL,
      RESP
   } state_t;

endpackage

// File: rtl/cache_victim_ptr.sv
// cache_victim_ptr: round-robin way pointer, wraps NUM_WAYS-1 -> 0.
// Ports: clk, rst (async high), inc (advance), ptr (current way).
module cache_victim_ptr #(
   parameter int NUM_WAYS = cache_pkg::NUM_WAYS,
   parameter int PTR_W    = $clog2(NUM_WAYS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   import cache_pkg::*;

   localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_WAYS - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
      end
   end

endmodule

// File: rtl/cache_miss_handler.sv
// cache_miss_handler: single-outstanding lookup/miss/fill sequencer.
// Ports: core req (valid/ready/addr), cache lookup (addr, hit, data),
// memory req/rsp, way fill, core rsp (data/hit/err), hit/miss stats.
module cache_miss_handler #(
   parameter int ADDR_W   = cache_pkg::ADDR_W,
   parameter int DATA_W   = cache_pkg::DATA_W,
   parameter int NUM_WAYS = cache_pkg::NUM_WAYS,
   parameter int TIMEOUT  = cache_pkg::TIMEOUT
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [ADDR_W-1:0]           req_addr,
   output logic [ADDR_W-1:0]           cache_addr,
   input  logic                        hit_in,
   input  logic [DATA_W-1:0]           cache_data_in,
   output logic                        mem_req_valid,
   input  logic                        mem_req_ready,
   output logic [ADDR_W-1:0]           mem_req_addr,
   input  logic                        mem_rsp_valid,
   input  logic [DATA_W-1:0]           mem_rsp_data,
   output logic                        fill_valid,
   output logic [$clog2(NUM_WAYS)-1:0] fill_way,
   output logic [ADDR_W-1:0]           fill_tag,
   output logic [DATA_W-1:0]           fill_data,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [DATA_W-1:0]           rsp_data,
   output logic                        rsp_hit,
   output logic                        rsp_err,
   output logic [15:0]                 hit_count,
   output logic [15:0]                 miss_count
);

   import cache_pkg::*;

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              hit_q;
   logic              err_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_inc;

   // cnt_inc is the number of MEM_WAIT cycles including this one
   assign cnt_inc      = cnt_q + 1'b1;
   assign cache_addr   = addr_q;
   assign mem_req_addr = addr_q;
   assign fill_tag     = addr_q;
   assign fill_data    = data_q;
   assign rsp_data     = data_q;
   assign rsp_hit      = hit_q;
   assign rsp_err      = err_q;

   cache_victim_ptr #(
      .NUM_WAYS (NUM_WAYS)
   ) u_victim (
      .clk (clk),
      .rst (rst),
      .inc (fill_valid),
      .ptr (fill_way)
   );

   always_comb begin
      state_d       = state_q;
      req_ready     = 1'b0;
      mem_req_valid = 1'b0;
      fill_valid    = 1'b0;
      rsp_valid     = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = LOOKUP;
         end
         LOOKUP: begin
            state_d = hit_in ? RESP : MEM_REQ;
         end
         MEM_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_d = MEM_WAIT;
         end
         MEM_WAIT: begin
            // returned data beats a timeout landing on the same cycle
            if (mem_rsp_valid) state_d = FILL;
            else if (cnt_inc == TO_VAL) state_d = RESP;
         end
         FILL: begin
            fill_valid = 1'b1;
            state_d    = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         data_q     <= '0;
         hit_q      <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  addr_q <= req_addr;
                  hit_q  <= 1'b0;
                  err_q  <= 1'b0;
               end
            end
            LOOKUP: begin
               if (hit_in) begin
                  data_q <= cache_data_in;
                  hit_q  <= 1'b1;
                  if (hit_count != 16'hFFFF)
                     hit_count <= hit_count + 16'd1;
               end else if (miss_count != 16'hFFFF) begin
                  miss_count <= miss_count + 16'd1;
               end
            end
            MEM_REQ: begin
               cnt_q <= '0;
            end
            MEM_WAIT: begin
               cnt_q <= cnt_inc;
               if (mem_rsp_valid) begin
                  data_q <= mem_rsp_data;
               end else if (cnt_inc == TO_VAL) begin
                  data_q <= '0;
                  err_q  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
